// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and parameter legality.
package adder_pkg;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry-ripple chunk of the pipelined adder plus its payload register.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 8,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned LSB = IDX * CW;
    localparam int unsigned MSB = LSB + CW - 1;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } payload_t;

    payload_t    pl_d;
    payload_t    pl_q;
    logic [CW:0] chunk;
    logic        msb_carry;

    always_comb begin
        chunk = {1'b0, up_a[MSB:LSB]} + {1'b0, up_b[MSB:LSB]} + {{CW{1'b0}}, up_carry};
        // Carry into this chunk's top bit, recovered from that bit's sum
        msb_carry = up_a[MSB] ^ up_b[MSB] ^ chunk[CW-1];
        pl_d.valid = up_valid;
        pl_d.a     = up_a;
        pl_d.b     = up_b;
        pl_d.sum   = up_sum;
        pl_d.sum[MSB:LSB] = chunk[CW-1:0];
        pl_d.carry = chunk[CW];
        pl_d.ovf   = msb_carry ^ chunk[CW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_q <= '0;
        end else if (en) begin
            pl_q <= pl_d;
        end
    end

    assign valid = pl_q.valid;
    assign a     = pl_q.a;
    assign b     = pl_q.b;
    assign sum   = pl_q.sum;
    assign carry = pl_q.carry;
    assign ovf   = pl_q.ovf;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready handshake on both sides.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = chunk_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("adder_pipe: WIDTH must be >= 2, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
    end

    logic             advance;
    logic             valid_p [STAGES+1];
    logic [WIDTH-1:0] a_p     [STAGES+1];
    logic [WIDTH-1:0] b_p     [STAGES+1];
    logic [WIDTH-1:0] sum_p   [STAGES+1];
    logic             carry_p [STAGES+1];
    logic             ovf_p   [STAGES+1];

    // Whole pipeline moves in lockstep; it freezes only when a held result is not taken.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    assign valid_p[0] = in_valid;
    assign a_p[0]     = a;
    assign b_p[0]     = b ^ {WIDTH{sub}};
    assign sum_p[0]   = '0;
    assign carry_p[0] = cin ^ sub;
    assign ovf_p[0]   = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (advance),
            .up_valid (valid_p[k]),
            .up_a     (a_p[k]),
            .up_b     (b_p[k]),
            .up_sum   (sum_p[k]),
            .up_carry (carry_p[k]),
            .valid    (valid_p[k+1]),
            .a        (a_p[k+1]),
            .b        (b_p[k+1]),
            .sum      (sum_p[k+1]),
            .carry    (carry_p[k+1]),
            .ovf      (ovf_p[k+1])
        );
    end

    assign out_valid = valid_p[STAGES];
    assign sum       = sum_p[STAGES];
    assign cout      = carry_p[STAGES];
    assign ovf       = ovf_p[STAGES];

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: directed scenarios plus a random stream.
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        v8, r8, cin8, sub8, ov8, ordy8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        v1, r1, cin1, sub1, ov1, ordy1, co1, of1;
    logic [31:0] a1, b1, s1;

    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int popped = 0;
    logic [33:0] sb[$];

    adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    adder_pipe #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(ordy1), .sum(s1),
        .cout(co1), .ovf(of1)
    );

    // Reference: {ovf, cout, sum} from the plain arithmetic definition.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [31:0] yy;
        logic [32:0] full;
        logic        v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, ci ^ s};
        v    = (x[31] == yy[31]) && (full[31] != x[31]);
        return {v, full};
    endfunction

    // Scoreboard monitor plus stall-stability check, sampled mid-cycle.
    bit          stall_prev = 1'b0;
    logic [33:0] held;
    logic [33:0] expv;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if ({out_valid, ovf, cout, sum} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL stall_hold got=%b_%h want=1_%h", out_valid, {ovf, cout, sum}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got=unexpected result %h want=none", sum);
                end else begin
                    expv = sb.pop_front();
                    popped++;
                    if ({ovf, cout, sum} !== expv) begin
                        failures++;
                        $display("FAIL sb_result got=%h want=%h", {ovf, cout, sum}, expv);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, cin, sub));
                pushed++;
            end
            stall_prev = out_valid && !out_ready;
            held = {ovf, cout, sum};
        end
    end

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        sub = s;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h want=0", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(posedge clk); #1 drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk); #1 drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk); #1 drive(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b want=0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, ovf, cout, sum} !== {3'b101, 32'h0000_0000}) begin
            failures++; $display("FAIL b2b_r0 got=%b%b%b_%h want=101_00000000", out_valid, ovf, cout, sum);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, ovf, cout, sum} !== {3'b110, 32'h8000_0000}) begin
            failures++; $display("FAIL b2b_r1 got=%b%b%b_%h want=110_80000000", out_valid, ovf, cout, sum);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, ovf, cout, sum} !== {3'b100, 32'h9999_999A}) begin
            failures++; $display("FAIL b2b_r2 got=%b%b%b_%h want=100_9999999a", out_valid, ovf, cout, sum);
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%b want=0", out_valid); end
    endtask

    task automatic test_subtract();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic        tc [4];
        logic [33:0] te [4];
        ta = '{32'd7, 32'd5, 32'h8000_0000, 32'd7};
        tb = '{32'd5, 32'd7, 32'd1, 32'd5};
        tc = '{1'b0, 1'b0, 1'b0, 1'b1};
        te = '{{2'b01, 32'h0000_0002}, {2'b00, 32'hFFFF_FFFE},
               {2'b11, 32'h7FFF_FFFF}, {2'b01, 32'h0000_0001}};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, ovf, cout, sum} !== {1'b1, te[i]}) begin
                failures++;
                $display("FAIL sub_%0d got=%b_%h want=1_%h", i, out_valid, {ovf, cout, sum}, te[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_sum [4];
        for (int i = 0; i < 4; i++) exp_sum[i] = 32'h1000_0000 * (i + 1) + 32'(i + 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h1000_0000 * (i + 1), 32'(i + 1), 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready, out_valid, sum} !== {2'b01, exp_sum[0]}) begin
                failures++;
                $display("FAIL bp_stall_%0d got=%b%b_%h want=01_%h", i, in_ready, out_valid, sum, exp_sum[0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, sum} !== {1'b1, exp_sum[i]}) begin
                failures++;
                $display("FAIL bp_drain_%0d got=%b_%h want=1_%h", i, out_valid, sum, exp_sum[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL bp_after got=%b%b want=01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'(i + 10), 32'(i + 20), 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_before got=%b want=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, ovf, cout, sum} !== {4'b0100, 32'h0}) begin
            failures++;
            $display("FAIL rmid_async got=%b%b%b%b_%h want=0100_00000000", out_valid, in_ready, ovf, cout, sum);
        end
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_stale got=valid seen want=none"); end
        drive(32'd1, 32'd1, 1'b0, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_early got=%b want=0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, sum} !== {1'b1, 32'd2}) begin
            failures++; $display("FAIL rmid_fresh got=%b_%h want=1_00000002", out_valid, sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0;
        v1 = 1'b1; a1 = 32'd3; b1 = 32'd4; cin1 = 1'b0; sub1 = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0; v1 = 1'b0;
        checks++;
        if ({ov1, co1, s1} !== {2'b10, 32'd7}) begin
            failures++; $display("FAIL s1_lat1 got=%b%b_%h want=10_00000007", ov1, co1, s1);
        end
        checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL w8_early got=%b want=0", ov8); end
        @(posedge clk); #1;
        checks++;
        if ({ov8, co8, of8, s8} !== {3'b110, 8'h01}) begin
            failures++; $display("FAIL w8_lat2 got=%b%b%b_%h want=110_01", ov8, co8, of8, s8);
        end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL s1_bubble got=%b want=0", ov1); end
    endtask

    task automatic test_random();
        int p0;
        int q0;
        int cyc;
        p0 = pushed;
        q0 = popped;
        cyc = 0;
        while ((pushed - p0) < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d pending want=0", sb.size()); end
        checks++; if ((pushed - p0) < 1000) begin failures++; $display("FAIL rand_count got=%0d want=1000", pushed - p0); end
        checks++;
        if ((popped - q0) != (pushed - p0)) begin
            failures++; $display("FAIL rand_balance got=%0d popped want=%0d", popped - q0, pushed - p0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b1;
        v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; ordy1 = 1'b1;
        test_reset();
        test_back_to_back();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
